serializer: RTL



---
 rtl/serializer_if.sv | 32 +++
 rtl/serializer.sv | 100 ++++++++++
 2 files changed

// File: rtl/serializer_if.sv
// Purpose : host-side bundle for the serializer: parallel word request in, serial bit stream and busy flag out.
// Ports   : data_i/data_mod_i/data_val_i (host -> serializer), ser_data_o/ser_data_val_o/busy_o (serializer -> host/link).
// Modports: master = host driving words, slave = serializer.
interface serializer_if #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int MOD_WIDTH      = $clog2(DATA_BUS_WIDTH)
);
  logic [DATA_BUS_WIDTH-1:0] data_i;
  logic [MOD_WIDTH-1:0]      data_mod_i;
  logic                      data_val_i;
  logic                      ser_data_o;
  logic                      ser_data_val_o;
  logic                      busy_o;

  modport master (
    output data_i,
    output data_mod_i,
    output data_val_i,
    input  ser_data_o,
    input  ser_data_val_o,
    input  busy_o
  );

  modport slave (
    input  data_i,
    input  data_mod_i,
    input  data_val_i,
    output ser_data_o,
    output ser_data_val_o,
    output busy_o
  );
endinterface

// File: rtl/serializer.sv
// Purpose : shifts out the top len bits of a parallel word, MSB first, one bit per clk_i (len from data_mod_i, 0 = full word).
// Latency : first bit valid the cycle after acceptance; len valid cycles, then one idle cycle before the next accept.
// Backpressure: none queued -- data_val_i while busy_o=1 is dropped silently.
// Ports   : clk_i, rst_n_i (async active-low), bus (serializer_if.slave: word request in, serial bit/valid and busy out).
module serializer #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int MOD_WIDTH      = $clog2(DATA_BUS_WIDTH)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  serializer_if.slave  bus
);

  // One extra bit so the counter can hold the full word length.
  localparam int                CNT_W    = MOD_WIDTH + 1;
  localparam logic [CNT_W-1:0]  FULL_LEN = CNT_W'(DATA_BUS_WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                    state_q, state_d;
  logic [DATA_BUS_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]          cnt_q,   cnt_d;
  logic                      ser_q,   ser_d;
  logic                      val_q,   val_d;
  logic [CNT_W-1:0]          len;

  // Zero means a full word; out-of-range counts (non power-of-2 widths) clamp to a full word.
  always_comb begin
    len = {1'b0, bus.data_mod_i};
    if (bus.data_mod_i == '0 || {1'b0, bus.data_mod_i} >= FULL_LEN) begin
      len = FULL_LEN;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ser_d   = ser_q;
    val_d   = val_q;
    case (state_q)
      IDLE: begin
        if (bus.data_val_i) begin
          // MSB goes straight to the output; the rest stays left-aligned in the shifter.
          state_d = SHIFT;
          ser_d   = bus.data_i[DATA_BUS_WIDTH-1];
          val_d   = 1'b1;
          shift_d = bus.data_i << 1;
          cnt_d   = len;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(1)) begin
          // Last bit was on the wire this cycle; the exit edge never accepts, giving one idle cycle.
          state_d = IDLE;
          ser_d   = 1'b0;
          val_d   = 1'b0;
          shift_d = '0;
          cnt_d   = '0;
        end else begin
          ser_d   = shift_q[DATA_BUS_WIDTH-1];
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ser_d   = 1'b0;
        val_d   = 1'b0;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      val_q   <= val_d;
    end
  end

  assign bus.ser_data_o     = ser_q;
  assign bus.ser_data_val_o = val_q;
  // Busy spans exactly the valid-bit cycles.
  assign bus.busy_o         = val_q;

endmodule
